// File: rtl/codeword_tx.sv
// codeword_tx: serialises one 7-bit Hamming codeword plus its overall parity as a
// 10-bit frame (start, codeword[0..6], parity, stop), each bit held CLKS_PER_BIT cycles.
// Latency: line falls one cycle after accept. in_ready is low while a frame is in flight.
module codeword_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:6] codeword,
  input  logic       parity,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  // A one-cycle bit time still needs a 1-bit counter so the compare below is legal.
  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [0:6]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  // Next-state, datapath and registered-output decode; outputs are computed from
  // the next state so every output pin comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q == S_IDLE) begin
      cyc_d = '0;
      if (in_valid && rdy_q) begin
        shift_d = codeword;
        par_d   = parity;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = S_START;
      end
    end else begin
      cyc_d = bit_end ? '0 : cyc_q + CW'(1);
      if (bit_end) begin
        unique case (state_q)
          S_START:  state_d = S_DATA;
          S_DATA: begin
            // Move the next codeword bit into position 0 for the line.
            shift_d = {shift_q[1:6], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd6) state_d = S_PARITY;
          end
          S_PARITY: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end

    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset forces the line high immediately, aborting any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_out   = tx_q;
  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_codeword_tx.sv
// Bench for codeword_tx: two instances (4 and 1 clocks per bit) checked every cycle
// against a frame-level model, plus directed frames with literal expected patterns.
`timescale 1ns/1ps
module tb_codeword_tx;
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld;
  logic [0:6] cw [2];
  logic [1:0] par;
  logic [1:0] rdy, txo, bsy, dn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codeword_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .codeword(cw[0]), .parity(par[0]), .tx_out(txo[0]), .busy(bsy[0]), .done(dn[0]));

  codeword_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .codeword(cw[1]), .parity(par[1]), .tx_out(txo[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 0) ? CPB_A : CPB_B;
  endfunction

  // Hamming(7,4): positions p1 p2 d1 p3 d2 d3 d4, then even overall parity.
  function automatic logic [0:7] hamming(input logic [3:0] d);
    logic p1, p2, p3;
    logic [0:6] c;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    c  = {p1, p2, d[3], p3, d[2], d[1], d[0]};
    return {c, ^c};
  endfunction

  // Frame-level model: a captured frame is a 10-bit list; the line shows bit pos/CPB.
  bit         m_act  [2];
  int         m_pos  [2];
  bit         m_done [2];
  logic [0:9] m_fr   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_pos[i]  = 0;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
          if (vld[i]) begin
            m_fr[i]  = {1'b0, cw[i], par[i], 1'b1};
            m_act[i] = 1'b1;
            m_pos[i] = 0;
          end
        end else begin
          m_pos[i]++;
          if (m_pos[i] == 10 * cpb(i)) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  // Single compare process: every cycle, both instances, all outputs.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int idx;
      idx = m_pos[i] / cpb(i);
      chk($sformatf("model tx_out[%0d]", i), 32'(txo[i]),
          32'(m_act[i] ? m_fr[i][idx] : 1'b1));
      chk($sformatf("model in_ready[%0d]", i), 32'(rdy[i]), 32'(!m_act[i]));
      chk($sformatf("model busy[%0d]", i), 32'(bsy[i]), 32'(m_act[i]));
      chk($sformatf("model done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
    end
  end

  // Send one frame on instance A, optionally changing codeword mid-frame; sample
  // the line once per bit starting the cycle after accept.
  task automatic send_a(input logic [0:6] c, input logic p, input logic [0:6] c2,
                        input int chg_at, output logic [9:0] bits, output int done_at,
                        output int ndone, output int rdy_hi);
    @(negedge clk);
    cw[0] = c; par[0] = p; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    bits = '0; done_at = -1; ndone = 0; rdy_hi = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == chg_at) cw[0] = c2;
      if (cyc <= 37 && (cyc - 1) % CPB_A == 0) bits = {bits[8:0], txo[0]};
      if (cyc <= 40 && rdy[0]) rdy_hi++;
      if (dn[0]) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] bits;
    logic [0:7] enc;
    int done_at, ndone, rdy_hi, nbusy;
    bit seen;

    rst_n = 1'b0;
    vld = 2'b11; par = '0; cw[0] = '0; cw[1] = '0;

    // Reset held with in_valid high: idle outputs, no frame.
    repeat (3) begin
      @(negedge clk);
      chk("reset tx_out", 32'(txo), 32'(2'b11));
      chk("reset in_ready", 32'(rdy), 32'(2'b11));
      chk("reset busy", 32'(bsy), 32'(2'b00));
      chk("reset done", 32'(dn), 32'(2'b00));
    end
    vld = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame.
    send_a(7'b1011010, 1'b0, 7'b1011010, 0, bits, done_at, ndone, rdy_hi);
    chk("single bits", 32'(bits), 32'(10'b0101101001));
    chk("single done cycle", 32'(done_at), 32'd41);
    chk("single done count", 32'(ndone), 32'd1);

    // Codeword changes during DATA are ignored; in_ready low throughout the frame.
    send_a(7'b1000000, 1'b0, 7'b0111111, 10, bits, done_at, ndone, rdy_hi);
    chk("midchg bits", 32'(bits), 32'(10'b0100000001));
    chk("midchg in_ready low", 32'(rdy_hi), 32'd0);
    chk("midchg done count", 32'(ndone), 32'd1);

    // Back-to-back with in_valid held; second frame presented in the done cycle.
    @(negedge clk);
    cw[0] = 7'b0000000; par[0] = 1'b0; vld[0] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (dn[0]) seen = 1'b1;
    end
    chk("b2b first done seen", 32'(seen), 32'd1);
    chk("b2b ready in done cycle", 32'(rdy[0]), 32'd1);
    chk("b2b idle gap high", 32'({bsy[0], txo[0]}), 32'(2'b01));
    cw[0] = 7'b1111111; par[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("b2b second start", 32'({bsy[0], txo[0]}), 32'(2'b10));
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      bits = {bits[8:0], txo[0]};
      repeat (CPB_A) @(negedge clk);
    end
    chk("b2b second bits", 32'(bits), 32'(10'b0111111111));
    repeat (5) @(negedge clk);

    // Abort by asynchronous reset during data bit index 2 (a 0 on the line).
    @(negedge clk);
    cw[0] = 7'b1101111; par[0] = 1'b0; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort line low before reset", 32'(txo[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort tx high async", 32'(txo[0]), 32'd1);
    chk("abort ready async", 32'(rdy[0]), 32'd1);
    chk("abort busy async", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (dn[0]) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    chk("abort ready after", 32'(rdy[0]), 32'd1);

    // One clock per bit, codeword from the encoder for data 3.
    enc = hamming(4'd3);
    chk("encoder pin", 32'(enc), 32'(8'b10000111));
    @(negedge clk);
    cw[1] = enc[0:6]; par[1] = enc[7]; vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    bits = '0; nbusy = 0; ndone = 0; done_at = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc <= 10) bits = {bits[8:0], txo[1]};
      if (bsy[1]) nbusy++;
      if (dn[1]) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      @(negedge clk);
    end
    chk("cpb1 bits literal", 32'(bits), 32'(10'b0100001111));
    chk("cpb1 bits vs encoder", 32'(bits), 32'({1'b0, enc, 1'b1}));
    chk("cpb1 busy cycles", 32'(nbusy), 32'd10);
    chk("cpb1 done count", 32'(ndone), 32'd1);
    chk("cpb1 done cycle", 32'(done_at), 32'd11);

    // Randomized traffic on both instances, inputs changing every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        cw[i]  = 7'($urandom);
        par[i] = 1'($urandom);
      end
    end
    @(negedge clk);
    vld = 2'b00;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
